calc_sequencer: RTL

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/calc_sequencer_if.sv | 23 ++
 rtl/operand_reg.sv | 36 +++
 rtl/calc_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and ALU operation codes for the calculator sequencer.
package calc_pkg;

    localparam logic [4:0] KEY_DIGIT_LO = 5'h00;
    localparam logic [4:0] KEY_DIGIT_HI = 5'h0F;
    localparam logic [4:0] KEY_ADD      = 5'h10;
    localparam logic [4:0] KEY_MUL      = 5'h11;
    localparam logic [4:0] KEY_AND      = 5'h12;
    localparam logic [4:0] KEY_EXE      = 5'h13;
    localparam logic [4:0] KEY_SUB      = 5'h14;
    localparam logic [4:0] KEY_OR       = 5'h15;
    localparam logic [4:0] KEY_CE       = 5'h16;
    localparam logic [4:0] KEY_CLR      = 5'h17;

    localparam logic [2:0] DIGITS_MAX   = 3'd4;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_WAIT_OP = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } alu_op_t;

    function automatic logic is_op_key(input logic [4:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL) ||
               (code == KEY_AND) || (code == KEY_OR);
    endfunction

    function automatic alu_op_t key_to_op(input logic [4:0] code);
        case (code)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_AND: return OP_AND;
            KEY_OR:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad, ALU and display signals of the calculator sequencer.
interface calc_sequencer_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic [15:0] display;
    logic [2:0]  state_o;

    modport master (
        output key_valid, key_code, alu_done, alu_result,
        input  op_a, op_b, alu_op, alu_start, display, state_o
    );

    modport slave (
        input  key_valid, key_code, alu_done, alu_result,
        output op_a, op_b, alu_op, alu_start, display, state_o
    );
endinterface

// File: rtl/operand_reg.sv
// 16-bit nibble shift register with a digit counter saturating at four digits.
module operand_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic        load,
    input  logic [3:0]  digit,
    input  logic [15:0] load_val,
    output logic [15:0] value,
    output logic [2:0]  count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= 16'h0000;
            count <= 3'd0;
        end else if (load) begin
            value <= load_val;
            count <= DIGITS_MAX;
        end else if (clr && shift) begin
            // fresh entry: the new digit replaces whatever was shown
            value <= {12'h000, digit};
            count <= 3'd1;
        end else if (clr) begin
            value <= 16'h0000;
            count <= 3'd0;
        end else if (shift && (count < DIGITS_MAX)) begin
            value <= {value[11:0], digit};
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: collects operands, issues ALU requests, shows results.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    calc_sequencer_if.slave  bus
);

    state_t      state, state_nxt;
    alu_op_t     op_q, op_nxt;
    logic        start_q, start_nxt;
    logic        a_clr, a_shift, a_load, b_clr, b_shift;
    logic [15:0] a_val, b_val;
    logic [2:0]  a_cnt, b_cnt;

    logic kv, is_digit, is_op, is_exe, is_ce, is_clr;
    assign kv       = bus.key_valid;
    assign is_digit = (bus.key_code <= KEY_DIGIT_HI);
    assign is_op    = is_op_key(bus.key_code);
    assign is_exe   = (bus.key_code == KEY_EXE);
    assign is_ce    = (bus.key_code == KEY_CE);
    assign is_clr   = (bus.key_code == KEY_CLR);

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        start_nxt = 1'b0;
        a_clr     = 1'b0;
        a_shift   = 1'b0;
        a_load    = 1'b0;
        b_clr     = 1'b0;
        b_shift   = 1'b0;
        if (kv && is_clr) begin
            a_clr     = 1'b1;
            b_clr     = 1'b1;
            op_nxt    = OP_ADD;
            state_nxt = ST_ENTER_A;
        end else begin
            case (state)
                ST_ENTER_A, ST_WAIT_OP: if (kv) begin
                    if (is_digit) begin
                        a_shift = 1'b1;
                        if (state == ST_ENTER_A && a_cnt == DIGITS_MAX - 3'd1)
                            state_nxt = ST_WAIT_OP;
                    end else if (is_op) begin
                        op_nxt    = key_to_op(bus.key_code);
                        b_clr     = 1'b1;
                        state_nxt = ST_ENTER_B;
                    end else if (is_ce) begin
                        a_clr     = 1'b1;
                        state_nxt = ST_ENTER_A;
                    end
                end
                ST_ENTER_B: if (kv) begin
                    if (is_digit)    b_shift = 1'b1;
                    else if (is_op)  op_nxt  = key_to_op(bus.key_code);
                    else if (is_ce)  b_clr   = 1'b1;
                    else if (is_exe) begin
                        start_nxt = 1'b1;
                        state_nxt = ST_EXEC;
                    end
                end
                // only the ALU completion (or CLR above) leaves EXEC
                ST_EXEC: if (bus.alu_done) begin
                    a_load    = 1'b1;
                    state_nxt = ST_SHOW;
                end
                ST_SHOW: if (kv) begin
                    if (is_digit) begin
                        a_clr     = 1'b1;
                        a_shift   = 1'b1;
                        state_nxt = ST_ENTER_A;
                    end else if (is_op) begin
                        op_nxt    = key_to_op(bus.key_code);
                        b_clr     = 1'b1;
                        state_nxt = ST_ENTER_B;
                    end else if (is_exe) begin
                        start_nxt = 1'b1;
                        state_nxt = ST_EXEC;
                    end else if (is_ce) begin
                        a_clr     = 1'b1;
                        state_nxt = ST_ENTER_A;
                    end
                end
                default: state_nxt = ST_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_ENTER_A;
            op_q    <= OP_ADD;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            start_q <= start_nxt;
        end
    end

    operand_reg u_reg_a (
        .clk(clk), .rst(rst), .clr(a_clr), .shift(a_shift), .load(a_load),
        .digit(bus.key_code[3:0]), .load_val(bus.alu_result),
        .value(a_val), .count(a_cnt)
    );

    operand_reg u_reg_b (
        .clk(clk), .rst(rst), .clr(b_clr), .shift(b_shift), .load(1'b0),
        .digit(bus.key_code[3:0]), .load_val(16'h0000),
        .value(b_val), .count(b_cnt)
    );

    assign bus.op_a      = a_val;
    assign bus.op_b      = b_val;
    assign bus.alu_op    = op_q;
    assign bus.alu_start = start_q;
    assign bus.state_o   = state;
    assign bus.display   = (state == ST_ENTER_B && b_cnt != 3'd0) ? b_val : a_val;

endmodule
